seq_divider: RTL

- Parametrised multi-cycle non-restoring divider for the Mini SRC datapath; successor to the combinational 32-bit divider.
- Computes quotient and remainder one bit per clock and presents {remainder, quotient} for the HI/LO register pair.
- Adds a start/busy/done handshake, runtime signed/unsigned mode, defined divide-by-zero and overflow results, and a WIDTH parameter.

---
 rtl/seq_divider.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Purpose  : Multi-cycle non-restoring divider, one quotient bit per clock.
//            Produces {remainder, quotient} for the HI/LO register pair.
//            Supports runtime signed/unsigned mode and a defined
//            divide-by-zero result: Z = {A, all-ones}.
// Ports    : clk        rising-edge clock
//            clr        synchronous active-high reset
//            start      request pulse, sampled only when not busy
//            is_signed  1 = two's-complement divide, sampled with start
//            A, B       dividend / divisor, sampled with start
//            busy       high while an operation is in flight
//            done       one-cycle pulse when Z becomes valid
//            Z          {remainder, quotient}, held until the next result
//            dbz        divide-by-zero flag (SEQ_DIVIDER_DBZ_EN builds only)
// Options  : SEQ_DIVIDER_DBZ_EN - adds the dbz port and a 2-cycle fast path
//            for a zero divisor.
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
`ifdef SEQ_DIVIDER_DBZ_EN
    output logic                 dbz,
`endif
    output logic [2*WIDTH-1:0]   Z
);

    localparam int              c_CW   = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;          // raw dividend, kept for the zero-divisor result
    logic [WIDTH-1:0] r_b;
    logic             r_sgn;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH:0]   r_p;          // signed partial remainder, one guard bit
    logic [c_CW-1:0]  r_cnt;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_zero;

    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH:0]   w_m_ext;
    logic [WIDTH:0]   w_p_sh;
    logic [WIDTH:0]   w_p_iter;
    logic [WIDTH-1:0] w_rem_mag;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;
    logic             w_b_zero;

    always_comb begin
        w_mag_a  = (r_sgn & r_a[WIDTH-1]) ? -r_a : r_a;
        w_mag_b  = (r_sgn & r_b[WIDTH-1]) ? -r_b : r_b;
        w_b_zero = (r_b == '0);
        w_m_ext  = {1'b0, r_m};
        // The top bit of P is dropped by the shift; the add/subtract result
        // always lies in [-M, M) so modulo 2^(WIDTH+1) arithmetic is exact.
        w_p_sh   = {r_p[WIDTH-1:0], r_q[WIDTH-1]};
        w_p_iter = r_p[WIDTH] ? (w_p_sh + w_m_ext) : (w_p_sh - w_m_ext);
        // Final correction: the true remainder lies in [0, M), so WIDTH bits
        // of the restored value are sufficient.
        w_rem_mag = r_p[WIDTH] ? (r_p[WIDTH-1:0] + r_m) : r_p[WIDTH-1:0];
        w_quo     = r_sign_q ? -r_q : r_q;
        w_rem     = r_sign_r ? -w_rem_mag : w_rem_mag;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state  <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            Z        <= '0;
`ifdef SEQ_DIVIDER_DBZ_EN
            dbz      <= 1'b0;
`endif
            r_a      <= '0;
            r_b      <= '0;
            r_sgn    <= 1'b0;
            r_q      <= '0;
            r_m      <= '0;
            r_p      <= '0;
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_sgn   <= is_signed;
                        busy    <= 1'b1;
`ifdef SEQ_DIVIDER_DBZ_EN
                        dbz     <= 1'b0;
`endif
                        r_state <= ST_LOAD;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_LOAD: begin
                    r_p      <= '0;
                    r_q      <= w_mag_a;
                    r_m      <= w_mag_b;
                    r_cnt    <= '0;
                    r_sign_q <= r_sgn & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                    r_sign_r <= r_sgn & r_a[WIDTH-1];
                    r_zero   <= w_b_zero;
`ifdef SEQ_DIVIDER_DBZ_EN
                    // A zero divisor bypasses the iteration entirely and goes
                    // straight to result registration.
                    r_state  <= w_b_zero ? ST_FIX : ST_ITER;
`else
                    r_state  <= ST_ITER;
`endif
                end

                ST_ITER: begin
                    r_p <= w_p_iter;
                    r_q <= {r_q[WIDTH-2:0], ~w_p_iter[WIDTH]};
                    if (r_cnt == c_LAST) begin
                        r_state <= ST_FIX;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end

                ST_FIX: begin
                    if (r_zero) begin
                        Z <= {r_a, {WIDTH{1'b1}}};
                    end else begin
                        Z <= {w_rem, w_quo};
                    end
`ifdef SEQ_DIVIDER_DBZ_EN
                    dbz     <= r_zero;
`endif
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= ST_DONE;
                end

                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
